pc_gen: RTL and testbench

- Parametrised next-generation program counter for the RISC-V core.
- Holds the fetch PC and selects the next PC each cycle. Sources: sequential increment, branch, JALR, trap vector, or a small return-address stack (RAS).
- Issues the fetch request to instruction memory with a valid/ready handshake.
- Sits between the control/execute stages and the instruction-memory port.

---
 rtl/pc_pkg.sv | 17 +
 rtl/pc_gen_ras_stack.sv | 56 +++++
 rtl/pc_gen.sv | 108 ++++++++++
 tb/tb_pc_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

    localparam int unsigned XLEN_DEF         = 32;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

    typedef enum logic [2:0] {
        SRC_TRAP,
        SRC_RAS,
        SRC_JALR,
        SRC_BR,
        SRC_HOLD,
        SRC_INC
    } next_src_e;

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned XLEN      = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top_data,
    output logic            empty,
    output logic            full
);
    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   top_ptr;
    logic [PW:0]     count;
    logic            do_replace;
    logic            do_push_new;
    logic            do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(RAS_DEPTH));
    assign top_data = mem[top_ptr];

    // Simultaneous push+pop on a non-empty stack swaps the top in place.
    assign do_replace  = push && pop && !empty;
    assign do_push_new = push && !do_replace;
    assign do_pop      = pop && !push && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (do_push_new) begin
            top_ptr <= top_ptr + PW'(1);
            if (!full)
                count <= count + (PW+1)'(1);
        end else if (do_pop) begin
            top_ptr <= top_ptr - PW'(1);
            count   <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_new)
            mem[top_ptr + PW'(1)] <= push_data;
        else if (do_replace)
            mem[top_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC register with prioritised next-PC selection, alignment check and RAS.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int unsigned     INC          = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_inc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] jalr_base,
    input  logic [XLEN-1:0] jalr_offset,
    input  logic            ret_pop,
    input  logic            call_push,
    input  logic [XLEN-1:0] push_addr,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vector,
    output logic            misalign,
    output logic            ras_empty,
    output logic            ras_full
);
    localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] ras_top;
    logic [XLEN-1:0] target;
    logic            ras_pop;
    logic            misalign_next;
    next_src_e       src;

    assign ras_pop     = jalr_en && ret_pop;
    assign pc_out      = pc_q;
    assign pc_plus_inc = pc_q + XLEN'(INC);

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk       (clk),
        .rst       (reset),
        .push      (call_push),
        .pop       (ras_pop),
        .push_data (push_addr),
        .top_data  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_comb begin
        src    = SRC_INC;
        target = pc_q;
        if (trap_en) begin
            src    = SRC_TRAP;
            target = trap_vector;
        end else if (ras_pop && !ras_empty) begin
            src    = SRC_RAS;
            target = ras_top & BIT0_CLR;
        end else if (jalr_en) begin
            src    = SRC_JALR;
            target = (jalr_base + jalr_offset) & BIT0_CLR;
        end else if (br_taken) begin
            src    = SRC_BR;
            target = br_target;
        end else if (stall || !fetch_ready || !fetch_valid) begin
            // No transfer happened (including the first edge out of reset).
            src = SRC_HOLD;
        end
    end

    always_comb begin
        pc_next       = pc_q;
        misalign_next = 1'b0;
        unique case (src)
            SRC_TRAP: pc_next = target;
            SRC_RAS, SRC_JALR, SRC_BR: begin
                if ((target[1:0] & ALIGN_MASK) != 2'b00)
                    misalign_next = 1'b1;
                else
                    pc_next = target;
            end
            SRC_INC:  pc_next = pc_plus_inc;
            default:  pc_next = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            pc_q        <= pc_next;
            fetch_valid <= 1'b1;
            misalign    <= misalign_next;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized bench for pc_gen against a queue-based reference model.
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall, fetch_ready, fetch_valid;
    logic [31:0] pc_out, pc_plus_inc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jalr_en;
    logic [31:0] jalr_base, jalr_offset;
    logic        ret_pop, call_push;
    logic [31:0] push_addr;
    logic        trap_en;
    logic [31:0] trap_vector;
    logic        misalign, ras_empty, ras_full;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_ras[$];

    pc_gen dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .pc_out      (pc_out),
        .pc_plus_inc (pc_plus_inc),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jalr_en     (jalr_en),
        .jalr_base   (jalr_base),
        .jalr_offset (jalr_offset),
        .ret_pop     (ret_pop),
        .call_push   (call_push),
        .push_addr   (push_addr),
        .trap_en     (trap_en),
        .trap_vector (trap_vector),
        .misalign    (misalign),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_ras.delete();
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},      pc_out,      m_pc);
        chk({tag, ".pc_inc"},  pc_plus_inc, m_pc + 32'd4);
        chk({tag, ".valid"},   {31'b0, fetch_valid}, {31'b0, m_valid});
        chk({tag, ".mis"},     {31'b0, misalign},    {31'b0, m_mis});
        chk({tag, ".empty"},   {31'b0, ras_empty},   {31'b0, (m_ras.size() == 0)});
        chk({tag, ".full"},    {31'b0, ras_full},    {31'b0, (m_ras.size() == 4)});
    endtask

    task automatic idle_inputs();
        stall = 0; fetch_ready = 1; br_taken = 0; br_target = 0;
        jalr_en = 0; jalr_base = 0; jalr_offset = 0; ret_pop = 0;
        call_push = 0; push_addr = 0; trap_en = 0; trap_vector = 0;
    endtask

    // One clock edge: predict from the architectural rules, then compare.
    task automatic cycle(input string tag);
        logic [31:0] n_pc, t;
        logic        n_mis, redirect, pop, nonempty;
        pop      = jalr_en && ret_pop;
        nonempty = (m_ras.size() != 0);
        n_pc     = m_pc;
        n_mis    = 1'b0;
        redirect = 1'b0;
        t        = 32'h0;
        if (trap_en)                n_pc = trap_vector;
        else if (pop && nonempty) begin t = m_ras[$] & ~32'h1; redirect = 1; end
        else if (jalr_en)         begin t = (jalr_base + jalr_offset) & ~32'h1; redirect = 1; end
        else if (br_taken)        begin t = br_target; redirect = 1; end
        else if (m_valid && fetch_ready && !stall) n_pc = m_pc + 32'd4;
        if (redirect) begin
            if (t % 4 != 0) n_mis = 1'b1;
            else            n_pc  = t;
        end
        @(posedge clk);
        #1;
        if (call_push && pop && nonempty) m_ras[m_ras.size()-1] = push_addr;
        else if (call_push) begin
            if (m_ras.size() == 4) void'(m_ras.pop_front());
            m_ras.push_back(push_addr);
        end else if (pop && nonempty) void'(m_ras.pop_back());
        m_pc    = n_pc;
        m_mis   = n_mis;
        m_valid = 1'b1;
        chk_all(tag);
    endtask

    initial begin
        logic [31:0] exp_ret [4];
        exp_ret[0] = 32'hE0; exp_ret[1] = 32'hD0; exp_ret[2] = 32'hC0; exp_ret[3] = 32'hB0;

        reset = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        chk_all("reset");
        chk("reset.pc_lit", pc_out, 32'h0);
        #24 reset = 1'b0;

        cycle("first_edge");
        chk("first.pc_lit", pc_out, 32'h0);
        cycle("inc4");  chk("inc.4",  pc_out, 32'h4);
        cycle("inc8");  chk("inc.8",  pc_out, 32'h8);
        cycle("incC");  chk("inc.C",  pc_out, 32'hC);
        cycle("inc10");

        stall = 1;
        for (int i = 0; i < 3; i++) cycle("stall");
        chk("stall.pc_lit", pc_out, 32'h10);
        stall = 0; fetch_ready = 0;
        for (int i = 0; i < 2; i++) cycle("not_ready");
        chk("not_ready.pc_lit", pc_out, 32'h10);
        fetch_ready = 1;
        cycle("ready_again");
        chk("ready.pc_lit", pc_out, 32'h14);

        br_taken = 1; br_target = 32'h20;
        cycle("br20");
        br_target = 32'h100; trap_en = 1; trap_vector = 32'h80; stall = 1;
        cycle("trap_over_br");
        chk("trap.pc_lit", pc_out, 32'h80);
        trap_en = 0;
        cycle("br_over_stall");
        chk("br.pc_lit", pc_out, 32'h100);
        br_taken = 0;

        jalr_en = 1; jalr_base = 32'h203; jalr_offset = 0;
        cycle("jalr_mis");
        chk("jalr_mis.lit", {31'b0, misalign}, 32'h1);
        chk("jalr_mis.pc_lit", pc_out, 32'h100);
        jalr_en = 0;
        cycle("mis_clear");
        chk("mis_clear.lit", {31'b0, misalign}, 32'h0);
        jalr_en = 1; jalr_base = 32'h1FF; jalr_offset = 1;
        cycle("jalr_ok");
        chk("jalr_ok.pc_lit", pc_out, 32'h200);
        jalr_en = 0;

        call_push = 1;
        for (int i = 0; i < 5; i++) begin
            push_addr = 32'hA0 + 32'(i) * 32'h10;
            cycle("push");
        end
        call_push = 0;
        chk("ras_full.lit", {31'b0, ras_full}, 32'h1);
        jalr_en = 1; ret_pop = 1; jalr_base = 32'h300; jalr_offset = 0;
        for (int i = 0; i < 4; i++) begin
            cycle("ret_pop");
            chk("ret_pop.lit", pc_out, exp_ret[i]);
        end
        chk("ras_empty.lit", {31'b0, ras_empty}, 32'h1);
        cycle("pop_empty");
        chk("pop_empty.lit", pc_out, 32'h300);
        jalr_en = 0; ret_pop = 0; stall = 0;

        br_taken = 1; br_target = 32'hFFFF_FFFC;
        cycle("br_top");
        br_taken = 0;
        cycle("wrap");
        chk("wrap.lit", pc_out, 32'h0);

        br_taken = 1; br_target = 32'h40; call_push = 1; push_addr = 32'h55C;
        cycle("br40_push");
        br_taken = 0; call_push = 0; stall = 1;
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk_all("async_reset");
        chk("async_reset.pc_lit", pc_out, 32'h0);
        @(posedge clk); #1;
        chk_all("reset_held");
        #3 reset = 1'b0;
        stall = 0;
        cycle("post_reset");

        for (int n = 0; n < 600; n++) begin
            stall       = ($urandom_range(0, 3) == 0);
            fetch_ready = ($urandom_range(0, 3) != 0);
            br_taken    = ($urandom_range(0, 5) == 0);
            br_target   = {$urandom_range(0, 4095), 2'b00} | 32'($urandom_range(0, 7) == 0 ? 2 : 0);
            jalr_en     = ($urandom_range(0, 5) == 0);
            ret_pop     = ($urandom_range(0, 1) == 0);
            jalr_base   = $urandom;
            jalr_offset = 32'($urandom_range(0, 3));
            call_push   = ($urandom_range(0, 3) == 0);
            push_addr   = {$urandom_range(0, 4095), 2'b00} | 32'($urandom_range(0, 7) == 0 ? 3 : 0);
            trap_en     = ($urandom_range(0, 15) == 0);
            trap_vector = $urandom;
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
